// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared state encoding and line-level constants for the
//                single-wire serial receiver and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } serial_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_if
//  Description : Line input and parallel word outputs of the serial receiver.
//                SERIAL_RX_PARITY_EN adds the parity_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_rx_if #(
    parameter int WIDTH = 8
);
    logic             i;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             frame_err;
    logic             busy;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output i,
`ifdef SERIAL_RX_PARITY_EN
        input  parity_err,
`endif
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  i,
`ifdef SERIAL_RX_PARITY_EN
        output parity_err,
`endif
        output data,
        output valid,
        output frame_err,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/serial_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_timer
//  Description : Loadable bit-period down-counter; expire_o is high in the
//                cycle whose closing edge is the mid-bit sample point.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    output logic                  expire_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Count 1 (not 0) marks expiry so a load of N yields exactly N cycles.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx
//  Description : Single-wire serial receiver: mid-bit sampling, LSB-first
//                data, stop-bit check. SERIAL_RX_PARITY_EN adds even parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_rx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    serial_rx_if.slave bus
);

    localparam int C_HALF  = CLKS_PER_BIT / 2;
    localparam int C_TMR_W = $clog2(CLKS_PER_BIT + 1);
    localparam int C_IDX_W = $clog2(WIDTH + 1);

    serial_state_t        state_q;
    logic [WIDTH-1:0]     shift_q;
    logic [WIDTH-1:0]     data_q;
    logic [C_IDX_W-1:0]   bit_idx_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_q;
    logic                 perr_q;
`endif

    logic                 w_expire;
    logic                 w_tmr_load;
    logic [C_TMR_W-1:0]   w_tmr_val;
    logic [WIDTH:0]       w_shift_cat;

    // New bit enters at the MSB so the first received bit ends up at bit 0.
    assign w_shift_cat = {bus.i, shift_q};

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = C_TMR_W'(CLKS_PER_BIT);
        case (state_q)
            IDLE: begin
                if (bus.i == START_BIT) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_TMR_W'(C_HALF);
                end
            end
            START:   w_tmr_load = w_expire && (bus.i == START_BIT);
            DATA:    w_tmr_load = w_expire;
`ifdef SERIAL_RX_PARITY_EN
            PARITY:  w_tmr_load = w_expire;
`endif
            default: w_tmr_load = 1'b0;
        endcase
    end

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (C_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .expire_o   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            data_q    <= '0;
            bit_idx_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.i == START_BIT) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (w_expire) begin
                        if (bus.i == START_BIT) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_expire) begin
                        shift_q   <= w_shift_cat[WIDTH:1];
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == C_IDX_W'(WIDTH - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (w_expire) begin
                        par_q   <= bus.i;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_expire) begin
                        if (bus.i == STOP_BIT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                            if (^{shift_q, par_q} == 1'b0) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                perr_q  <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A line held low must return idle before a new start counts.
                    if (bus.i == LINE_IDLE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_rx
//  Description : Directed self-checking bench for serial_rx (WIDTH=8, 4 clk/bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_rx_if #(.WIDTH(WIDTH)) bus ();

    serial_rx #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    int         t0;
    int         vcyc[$];
    logic [7:0] vdat[$];
    int         fcyc[$];
    int         pcyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Each advance moves into the next cycle and logs any output pulses seen there.
    task automatic adv(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.valid === 1'b1) begin
                vcyc.push_back(cyc);
                vdat.push_back(bus.data);
            end
            if (bus.frame_err === 1'b1) fcyc.push_back(cyc);
`ifdef SERIAL_RX_PARITY_EN
            if (bus.parity_err === 1'b1) pcyc.push_back(cyc);
`endif
        end
    endtask

    task automatic put(input logic v, input int n);
        bus.i = v;
        adv(n);
    endtask

    task automatic put_bits(input logic [7:0] d, input int nbits);
        for (int k = 0; k < nbits; k++) put(d[k], CPB);
    endtask

    task automatic clear_log();
        vcyc.delete();
        vdat.delete();
        fcyc.delete();
        pcyc.delete();
    endtask

    initial begin
        bus.i = 1'b1;
        rst   = 1'b1;
        adv(3);
        chk("rst_data",  32'(bus.data),      32'h0);
        chk("rst_valid", 32'(bus.valid),     32'h0);
        chk("rst_ferr",  32'(bus.frame_err), 32'h0);
        chk("rst_busy",  32'(bus.busy),      32'h0);
        rst = 1'b0;
        put(1'b1, 3);

        // Good frame 0xA5
        clear_log();
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'hA5, 8);
        put(1'b1, CPB);
        put(1'b1, 2);
        chk("good_nvalid", 32'(vcyc.size()), 32'd1);
        chk("good_vcyc",   32'(vcyc[0]),     32'(t0 + 39));
        chk("good_vdat",   32'(vdat[0]),     32'hA5);
        chk("good_data",   32'(bus.data),    32'hA5);
        chk("good_nferr",  32'(fcyc.size()), 32'd0);
        chk("good_busy",   32'(bus.busy),    32'h0);

        // One-cycle glitch
        clear_log();
        t0 = cyc;
        put(1'b0, 1);
        chk("glitch_busy_t1", 32'(bus.busy), 32'h1);
        put(1'b1, 1);
        chk("glitch_busy_t2", 32'(bus.busy), 32'h1);
        put(1'b1, 1);
        chk("glitch_busy_t3", 32'(bus.busy), 32'h0);
        put(1'b1, 4);
        chk("glitch_nvalid", 32'(vcyc.size()), 32'd0);
        chk("glitch_nferr",  32'(fcyc.size()), 32'd0);
        chk("glitch_data",   32'(bus.data),    32'hA5);

        // Frame error: 0x3C, stop bit low, line held low 10 more cycles
        clear_log();
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'h3C, 8);
        put(1'b0, CPB + 10);
        chk("ferr_busy_low", 32'(bus.busy), 32'h1);
        bus.i = 1'b1;
        chk("ferr_busy_ret", 32'(bus.busy), 32'h1);
        put(1'b1, 1);
        chk("ferr_busy_off", 32'(bus.busy),    32'h0);
        put(1'b1, 8);
        chk("ferr_nferr",    32'(fcyc.size()), 32'd1);
        chk("ferr_fcyc",     32'(fcyc[0]),     32'(t0 + 39));
        chk("ferr_nvalid",   32'(vcyc.size()), 32'd0);
        chk("ferr_data",     32'(bus.data),    32'hA5);

        // Back-to-back 0x01 then 0xFE
        clear_log();
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'h01, 8);
        put(1'b1, CPB - 1);
        put(1'b0, CPB);
        put_bits(8'hFE, 8);
        put(1'b1, CPB);
        put(1'b1, 2);
        chk("b2b_nvalid", 32'(vcyc.size()), 32'd2);
        chk("b2b_vcyc0",  32'(vcyc[0]),     32'(t0 + 39));
        chk("b2b_vdat0",  32'(vdat[0]),     32'h01);
        chk("b2b_vcyc1",  32'(vcyc[1]),     32'(t0 + 78));
        chk("b2b_vdat1",  32'(vdat[1]),     32'hFE);
        chk("b2b_nferr",  32'(fcyc.size()), 32'd0);

        // Reset in the middle of 0xC3
        clear_log();
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'hC3, 4);
        rst = 1'b1;
        put(1'b0, 1);
        rst = 1'b0;
        chk("mrst_busy", 32'(bus.busy),  32'h0);
        chk("mrst_data", 32'(bus.data),  32'h0);
        put(1'b1, 20);
        chk("mrst_nvalid", 32'(vcyc.size()), 32'd0);
        chk("mrst_nferr",  32'(fcyc.size()), 32'd0);
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'h55, 8);
        put(1'b1, CPB);
        put(1'b1, 2);
        chk("post_nvalid", 32'(vcyc.size()), 32'd1);
        chk("post_vcyc",   32'(vcyc[0]),     32'(t0 + 39));
        chk("post_data",   32'(bus.data),    32'h55);

`ifdef SERIAL_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        clear_log();
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'h07, 8);
        put(1'b1, CPB);
        put(1'b1, CPB);
        put(1'b1, 2);
        chk("par_ok_nvalid", 32'(vcyc.size()), 32'd1);
        chk("par_ok_vcyc",   32'(vcyc[0]),     32'(t0 + 43));
        chk("par_ok_data",   32'(bus.data),    32'h07);
        chk("par_ok_nperr",  32'(pcyc.size()), 32'd0);

        clear_log();
        t0 = cyc;
        put(1'b0, CPB);
        put_bits(8'h07, 8);
        put(1'b0, CPB);
        put(1'b1, CPB);
        put(1'b1, 2);
        chk("par_bad_nperr",  32'(pcyc.size()), 32'd1);
        chk("par_bad_pcyc",   32'(pcyc[0]),     32'(t0 + 43));
        chk("par_bad_nvalid", 32'(vcyc.size()), 32'd0);
        chk("par_bad_data",   32'(bus.data),    32'h07);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_rx.md
# serial_rx

Single-wire serial receiver: recovers framed words from a 1-bit line and presents them in parallel. It is the far end of the single-bit signal paths in the design: a transmitter drives the line, and `serial_rx` samples it mid-bit, checks framing, and reports each word with a one-cycle valid pulse. The line is idle-high; each frame is a start bit (0), WIDTH data bits LSB-first, an optional parity bit, and a stop bit (1).

## Interface
- `WIDTH`, default 8, number of data bits per frame (≥1).
- `CLKS_PER_BIT`, default 4, clock cycles per bit period (≥2); half-period `H = CLKS_PER_BIT/2`, rounded down.
- `clk`  input  1  sole clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `i`  input  1  serial line, synchronous to `clk`, idle high.
- `data`  output  WIDTH  last accepted word; holds until the next accepted word.
- `valid`  output  1  one-cycle pulse: `data` was updated with a good frame.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled 0.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, all counters 0.
- States: IDLE, START, DATA, (PARITY), STOP, BREAK.
- IDLE: when `i`=0 is sampled, go to START and load the bit timer with H.
- START: at timer expiry, resample `i`.
  - 0: go to DATA and reload the timer with CLKS_PER_BIT.
  - 1: treat as a glitch and return to IDLE with no outputs.
- DATA: at each expiry, shift `i` into bit `k` (LSB first) of a shadow register. After bit WIDTH−1, go to PARITY if enabled, otherwise STOP.
- STOP: at expiry, sample `i`.
  - 1: copy shadow to `data`, pulse `valid`, go to IDLE.
  - 0: pulse `frame_err`, `data` unchanged, go to BREAK.
- BREAK: wait until `i`=1 is sampled, then go to IDLE. This prevents a held-low line from being read as a new start.
- Error precedence: frame error outranks parity error. At most one of `valid`/`frame_err`/`parity_err` pulses per frame.
- `rst` mid-frame: the frame is discarded, state returns to IDLE next cycle, and no pulse is emitted.

## Timing
- `t0` is the first cycle in IDLE where `i`=0 is sampled.
- Start sample at `t0+H`. Data bit `k` sampled at `t0+H+(k+1)·CLKS_PER_BIT`.
- Stop sample at `S = t0+H+(WIDTH+1+P)·CLKS_PER_BIT`, with `P`=1 if parity is enabled, else 0.
- `valid`/`frame_err` are high in cycle `S+1` only. `data` is valid from `S+1`.
- Back-to-back frames: IDLE is entered at `S+1`, so a start bit sampled at `S+1` is accepted (`t0' = S+1`).
- `busy` rises at `t0+1` and falls at `S+1` on a good frame. On a glitch it falls at `t0+H+1`.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - Adds the PARITY state and output `parity_err` (1 bit, reset 0).
  - The parity bit is sampled one period after the last data bit. Even parity: XOR of data bits plus parity bit must be 0.
  - On mismatch with a good stop bit: pulse `parity_err` at `S+1`, no `valid`, `data` unchanged.
- Not defined: no PARITY state, no `parity_err` port, `P`=0.

## Structure
- Shared package `serial_pkg`:
  - state enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `BREAK`);
  - line constants `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1;
  - reused by the future `serial_tx`.
- One sub-module, `serial_bit_timer`:
  - down-counter of width `$clog2(CLKS_PER_BIT+1)`, with load value and `expire` pulse;
  - instantiated once.
- Bit index counter width `$clog2(WIDTH+1)`.

## Test plan
All scenarios use WIDTH=8, CLKS_PER_BIT=4 (H=2).
- **Good frame:** send 0xA5 with start at `t0` → `valid`=1 only at `t0+39`, `data`=0xA5, `frame_err`=0.
- **Glitch:** `i` low for 1 cycle at `t0` → `busy` high `t0+1..t0+2`, no pulse, `data` unchanged.
- **Frame error:** send 0x3C with stop bit 0, line held low 10 more cycles → `frame_err` at `t0+39`, `data` unchanged, `busy` high until 1 cycle after `i` returns high.
- **Back-to-back:** 0x01 then 0xFE with the second start at `t0+39` → `valid` at `t0+39` (0x01) and `t0+78` (0xFE).
- **Reset mid-frame:** `rst` at `t0+20` for 1 cycle, then line idle → no `valid`, `busy`=0 at `t0+21`; a subsequent 0x55 frame is received correctly.
- **Parity (`SERIAL_RX_PARITY_EN`):** 0x07 with parity bit 1 → `valid` at `t0+43`. Same frame with parity bit 0 → `parity_err` at `t0+43`, no `valid`.
